// File: rtl/alu_rs_scheduler_if.sv
// Handshake bundle between the ALU reservation-station scheduler and its
// neighbours: dual-issue allocation lanes, CDB wakeup ports and the ALU
// dispatch handshake.
interface alu_rs_scheduler_if #(
    parameter int DEPTH     = 4,
    parameter int TAG_W     = 4,
    parameter int CDB_PORTS = 2
);
    localparam int IDX_W = $clog2(DEPTH);

    logic                       flush;
    logic [1:0]                 alloc_ready;
    logic [2*IDX_W-1:0]         alloc_index;
    logic [1:0]                 alloc_taken;
    logic [3:0]                 alloc_op_ready;
    logic [4*TAG_W-1:0]         alloc_op_tag;
    logic [CDB_PORTS-1:0]       cdb_valid;
    logic [CDB_PORTS*TAG_W-1:0] cdb_tag;
    logic                       issue_valid;
    logic [IDX_W-1:0]           issue_index;
    logic                       issue_ready;
    logic [IDX_W:0]             occupancy;

    // Pipeline side: issues allocations, broadcasts results, accepts dispatch
    modport master (
        output flush, alloc_taken, alloc_op_ready, alloc_op_tag,
               cdb_valid, cdb_tag, issue_ready,
        input  alloc_ready, alloc_index, issue_valid, issue_index, occupancy
    );

    // Scheduler side
    modport slave (
        input  flush, alloc_taken, alloc_op_ready, alloc_op_tag,
               cdb_valid, cdb_tag, issue_ready,
        output alloc_ready, alloc_index, issue_valid, issue_index, occupancy
    );
endinterface

// File: rtl/alu_rs_scheduler.sv
// ALU reservation-station slot manager and issue scheduler.
// Owns per-slot busy / operand-ready / tag / age state, hands out up to two
// free slots per cycle, wakes operands from the CDB and dispatches the oldest
// fully-ready slot. All outputs depend on registered state only.
module alu_rs_scheduler #(
    parameter int DEPTH     = 4,
    parameter int TAG_W     = 4,
    parameter int CDB_PORTS = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    alu_rs_scheduler_if.slave rs
);
    localparam int IDX_W = $clog2(DEPTH);

    typedef logic [IDX_W-1:0] idx_t;
    typedef logic [TAG_W-1:0] tag_t;

    // Registered slot state; older[i][j] = slot i was allocated before slot j
    logic [DEPTH-1:0] busy;
    logic [1:0]       op_rdy [DEPTH];
    tag_t             op_tag [DEPTH][2];
    logic [DEPTH-1:0] older  [DEPTH];

    // Decoded inputs and derived control
    tag_t             bc_tag   [CDB_PORTS];
    tag_t             in_tag   [2][2];
    logic [1:0]       in_rdy   [2];
    logic [1:0]       wake     [DEPTH];
    logic             found0, found1;
    idx_t             free0, free1;
    idx_t             tgt      [2];
    logic [1:0]       do_alloc;
    logic             alloc_err;
    logic [DEPTH-1:0] elig;
    logic             any_elig;
    logic             oldest;
    idx_t             issue_sel;
    logic             issue_fire;
    logic [DEPTH-1:0] busy_keep;

    // True when any valid CDB port broadcasts the given tag this cycle
    function automatic logic cdb_hit(input tag_t t, input logic [CDB_PORTS-1:0] v,
                                     input tag_t bt [CDB_PORTS]);
        logic hit;
        hit = 1'b0;
        for (int p = 0; p < CDB_PORTS; p++) begin
            if (v[p] && bt[p] == t) hit = 1'b1;
        end
        return hit;
    endfunction

    // Unpack CDB tags, incoming operand tags and same-cycle bypassed ready bits
    always_comb begin
        // NOTE: combinational blocks use blocking '=' so later statements see
        // the values just computed, exactly like wires.
        for (int p = 0; p < CDB_PORTS; p++) begin
            bc_tag[p] = rs.cdb_tag[p*TAG_W +: TAG_W];
        end
        for (int l = 0; l < 2; l++) begin
            for (int o = 0; o < 2; o++) begin
                in_tag[l][o] = rs.alloc_op_tag[(2*l+o)*TAG_W +: TAG_W];
                in_rdy[l][o] = rs.alloc_op_ready[2*l+o] |
                               cdb_hit(rs.alloc_op_tag[(2*l+o)*TAG_W +: TAG_W],
                                       rs.cdb_valid, bc_tag);
            end
        end
    end

    // Operand wakeup of waiting operands in busy slots
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            for (int o = 0; o < 2; o++) begin
                wake[i][o] = busy[i] & ~op_rdy[i][o] &
                             cdb_hit(op_tag[i][o], rs.cdb_valid, bc_tag);
            end
        end
    end

    // Lowest and second-lowest free slots feed the two allocation lanes
    always_comb begin
        // NOTE: every variable gets a default before the loop so no path
        // leaves it unassigned, which would otherwise infer a latch.
        found0 = 1'b0;
        found1 = 1'b0;
        free0  = '0;
        free1  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!busy[i]) begin
                if (!found0) begin
                    found0 = 1'b1;
                    free0  = idx_t'(i);
                end else if (!found1) begin
                    found1 = 1'b1;
                    free1  = idx_t'(i);
                end
            end
        end
    end

    // Lane targets and legality; lane 1 falls back to the lane-0 slot when it
    // is the only free one and lane 0 is idle
    always_comb begin
        tgt[0]    = free0;
        tgt[1]    = found1 ? free1 : free0;
        alloc_err = (rs.alloc_taken[0] & ~found0) |
                    (rs.alloc_taken[1] & ~(found0 | found1)) |
                    (rs.alloc_taken[0] & rs.alloc_taken[1] & ~found1);
        do_alloc  = (alloc_err || rs.flush) ? 2'b00 : rs.alloc_taken;
    end

    // Oldest-ready select: the eligible slot older than every other eligible one
    always_comb begin
        issue_sel = '0;
        oldest    = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            elig[i] = busy[i] & op_rdy[i][0] & op_rdy[i][1];
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (elig[i]) begin
                oldest = 1'b1;
                for (int j = 0; j < DEPTH; j++) begin
                    if (j != i && elig[j] && !older[i][j]) oldest = 1'b0;
                end
                if (oldest) issue_sel = idx_t'(i);
            end
        end
        any_elig   = |elig;
        issue_fire = any_elig & rs.issue_ready;
        busy_keep  = busy;
        if (issue_fire) busy_keep[issue_sel] = 1'b0;
    end

    // Busy, ready and age state: wake, then free on dispatch, then allocate
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking '<=' so every register
        // samples pre-edge values; later assignments in the block take priority.
        if (!rst_n) begin
            busy <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                op_rdy[i] <= '0;
                older[i]  <= '0;
            end
        end else if (rs.flush) begin
            busy <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                op_rdy[i] <= '0;
                older[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                op_rdy[i] <= op_rdy[i] | wake[i];
            end
            if (issue_fire) begin
                busy[issue_sel]  <= 1'b0;
                older[issue_sel] <= '0;
            end
            for (int l = 0; l < 2; l++) begin
                if (do_alloc[l]) begin
                    busy[tgt[l]]   <= 1'b1;
                    op_rdy[tgt[l]] <= in_rdy[l];
                    older[tgt[l]]  <= '0;
                    for (int j = 0; j < DEPTH; j++) begin
                        older[j][tgt[l]] <= busy_keep[j];
                    end
                end
            end
            if (do_alloc[0] && do_alloc[1]) older[tgt[0]][tgt[1]] <= 1'b1;
        end
    end

    // Operand tag capture on allocation
    always_ff @(posedge clk) begin
        // NOTE: tag storage is deliberately not reset; a tag is only consulted
        // while its slot is busy, and busy is always written together with it.
        for (int l = 0; l < 2; l++) begin
            if (do_alloc[l]) begin
                op_tag[tgt[l]][0] <= in_tag[l][0];
                op_tag[tgt[l]][1] <= in_tag[l][1];
            end
        end
    end

    // Outputs come from registered state only
    assign rs.alloc_ready = {found1, found0};
    assign rs.alloc_index = {free1, free0};
    assign rs.issue_valid = any_elig;
    assign rs.issue_index = issue_sel;
    assign rs.occupancy   = (IDX_W+1)'($countones(busy));

    // Illegal lane targeting is a caller error; the allocation is dropped
    assert property (@(posedge clk) disable iff (!rst_n) !alloc_err);

endmodule

// File: tb/tb_alu_rs_scheduler.sv
// Self-checking bench for alu_rs_scheduler: directed scenarios plus random
// traffic, checked by a scoreboard fed from a sequence-number reference model.
module tb_alu_rs_scheduler;
    localparam int DEPTH = 4;
    localparam int TAG_W = 4;
    localparam int CDB_P = 2;
    localparam int IDX_W = 2;

    typedef struct {
        logic [1:0]       ar;
        logic [2*IDX_W-1:0] ai;
        logic             iv;
        logic [IDX_W-1:0] ii;
        logic [IDX_W:0]   occ;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    exp_t exp_q [$];
    exp_t mon_e;

    alu_rs_scheduler_if #(.DEPTH(DEPTH), .TAG_W(TAG_W), .CDB_PORTS(CDB_P)) bus ();

    alu_rs_scheduler #(.DEPTH(DEPTH), .TAG_W(TAG_W), .CDB_PORTS(CDB_P)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .rs    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: each slot remembers when it was allocated
    bit         m_busy [DEPTH];
    bit [1:0]   m_rdy  [DEPTH];
    logic [3:0] m_tag  [DEPTH][2];
    int         m_seq  [DEPTH];
    int         next_seq;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic bit cdb_match(input logic [3:0] t, input logic [1:0] cv, input logic [7:0] ct);
        bit hit;
        hit = 0;
        for (int p = 0; p < CDB_P; p++) begin
            if (cv[p] && ct[p*4 +: 4] == t) hit = 1;
        end
        return hit;
    endfunction

    function automatic exp_t model_out();
        exp_t e;
        int   nfree;
        int   best;
        e.ar = '0; e.ai = '0; e.iv = 1'b0; e.ii = '0; e.occ = '0;
        nfree = 0;
        best  = -1;
        for (int i = 0; i < DEPTH; i++) begin
            if (!m_busy[i]) begin
                if (nfree == 0) begin e.ar[0] = 1'b1; e.ai[1:0] = 2'(i); end
                else if (nfree == 1) begin e.ar[1] = 1'b1; e.ai[3:2] = 2'(i); end
                nfree++;
            end else begin
                e.occ = e.occ + 3'd1;
                if (m_rdy[i] == 2'b11 && (best < 0 || m_seq[i] < m_seq[best])) best = i;
            end
        end
        if (best >= 0) begin
            e.iv = 1'b1;
            e.ii = 2'(best);
        end
        return e;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) begin
            m_busy[i] = 0;
            m_rdy[i]  = 2'b00;
        end
    endtask

    task automatic model_alloc(input int s, input int lane, input logic [3:0] rd,
                               input logic [15:0] tg, input logic [1:0] cv, input logic [7:0] ct);
        m_busy[s] = 1;
        m_seq[s]  = next_seq;
        next_seq++;
        for (int o = 0; o < 2; o++) begin
            m_tag[s][o] = tg[(2*lane+o)*4 +: 4];
            m_rdy[s][o] = rd[2*lane+o] | cdb_match(tg[(2*lane+o)*4 +: 4], cv, ct);
        end
    endtask

    task automatic model_update(input logic [1:0] tk, input logic [3:0] rd, input logic [15:0] tg,
                                input logic [1:0] cv, input logic [7:0] ct, input logic ir,
                                input logic fl, input exp_t e);
        if (fl) begin
            model_reset();
            return;
        end
        for (int i = 0; i < DEPTH; i++) begin
            for (int o = 0; o < 2; o++) begin
                if (m_busy[i] && !m_rdy[i][o] && cdb_match(m_tag[i][o], cv, ct)) m_rdy[i][o] = 1'b1;
            end
        end
        if (e.iv && ir) m_busy[e.ii] = 0;
        if (tk[0]) model_alloc(int'(e.ai[1:0]), 0, rd, tg, cv, ct);
        if (tk[1]) model_alloc(e.ar[1] ? int'(e.ai[3:2]) : int'(e.ai[1:0]), 1, rd, tg, cv, ct);
    endtask

    // One clock of stimulus: predict this cycle's outputs, drive, step model
    task automatic cycle(input logic [1:0] tk, input logic [3:0] rd, input logic [15:0] tg,
                         input logic [1:0] cv, input logic [7:0] ct, input logic ir, input logic fl);
        exp_t e;
        e = model_out();
        exp_q.push_back(e);
        bus.alloc_taken    = tk;
        bus.alloc_op_ready = rd;
        bus.alloc_op_tag   = tg;
        bus.cdb_valid      = cv;
        bus.cdb_tag        = ct;
        bus.issue_ready    = ir;
        bus.flush          = fl;
        @(posedge clk);
        model_update(tk, rd, tg, cv, ct, ir, fl, e);
        #1;
    endtask

    task automatic drive_idle();
        bus.alloc_taken    = 2'b00;
        bus.alloc_op_ready = 4'b0000;
        bus.alloc_op_tag   = '0;
        bus.cdb_valid      = 2'b00;
        bus.cdb_tag        = '0;
        bus.issue_ready    = 1'b0;
        bus.flush          = 1'b0;
    endtask

    task automatic expect_state(input string n, input logic [1:0] ar, input logic [3:0] ai,
                                input logic [2:0] occ);
        check({n, "_alloc_ready"}, 32'(bus.alloc_ready), 32'(ar));
        check({n, "_alloc_index"}, 32'(bus.alloc_index), 32'(ai));
        check({n, "_occupancy"},   32'(bus.occupancy),   32'(occ));
    endtask

    task automatic expect_issue(input string n, input logic iv, input logic [1:0] ii);
        check({n, "_issue_valid"}, 32'(bus.issue_valid), 32'(iv));
        if (iv) check({n, "_issue_index"}, 32'(bus.issue_index), 32'(ii));
    endtask

    // Scoreboard monitor: compares every presented output set on the falling edge
    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                check("sb_alloc_ready", 32'(bus.alloc_ready), 32'(mon_e.ar));
                check("sb_alloc_index", 32'(bus.alloc_index), 32'(mon_e.ai));
                check("sb_issue_valid", 32'(bus.issue_valid), 32'(mon_e.iv));
                if (mon_e.iv) check("sb_issue_index", 32'(bus.issue_index), 32'(mon_e.ii));
                check("sb_occupancy", 32'(bus.occupancy), 32'(mon_e.occ));
            end
        end
    end

    // Watchdog so the run always ends
    initial begin
        #1000000;
        $display("FAIL watchdog timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  tk;
        logic [3:0]  rd;
        logic [15:0] tg;
        logic [7:0]  ct;
        exp_t        e;
        int          pick;

        checks   = 0;
        errors   = 0;
        next_seq = 0;
        model_reset();
        drive_idle();
        rst_n = 1'b0;
        #3;
        expect_state("reset", 2'b11, 4'b0100, 3'd0);
        expect_issue("reset", 1'b0, 2'd0);
        check("reset_issue_index", 32'(bus.issue_index), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Dual allocation, all operands ready, drained in age order
        cycle(2'b11, 4'b1111, 16'h0000, 2'b00, 8'h00, 1'b1, 1'b0);
        expect_issue("dual_first", 1'b1, 2'd0);
        cycle(2'b00, 4'b0000, 16'h0000, 2'b00, 8'h00, 1'b1, 1'b0);
        expect_issue("dual_second", 1'b1, 2'd1);
        cycle(2'b00, 4'b0000, 16'h0000, 2'b00, 8'h00, 1'b1, 1'b0);
        expect_issue("dual_done", 1'b0, 2'd0);
        expect_state("dual_done", 2'b11, 4'b0100, 3'd0);

        // Waiting operand woken by CDB port 1
        cycle(2'b01, 4'b1110, 16'h0005, 2'b00, 8'h00, 1'b0, 1'b0);
        expect_issue("wait_tag5", 1'b0, 2'd0);
        cycle(2'b00, 4'b0000, 16'h0000, 2'b10, 8'h50, 1'b0, 1'b0);
        expect_issue("woken_tag5", 1'b1, 2'd0);
        cycle(2'b00, 4'b0000, 16'h0000, 2'b00, 8'h00, 1'b1, 1'b0);

        // Same-cycle bypass on allocation
        cycle(2'b01, 4'b1110, 16'h0003, 2'b01, 8'h03, 1'b0, 1'b0);
        expect_issue("bypass", 1'b1, 2'd0);
        cycle(2'b00, 4'b0000, 16'h0000, 2'b00, 8'h00, 1'b1, 1'b0);

        // Age order: slots allocated 2, 0, 3 (slot 1 holds an unrelated waiter)
        cycle(2'b11, 4'b1010, 16'h0908, 2'b00, 8'h00, 1'b0, 1'b0);
        cycle(2'b01, 4'b1110, 16'h0002, 2'b00, 8'h00, 1'b0, 1'b0);
        cycle(2'b00, 4'b0000, 16'h0000, 2'b01, 8'h08, 1'b0, 1'b0);
        cycle(2'b00, 4'b0000, 16'h0000, 2'b00, 8'h00, 1'b1, 1'b0);
        cycle(2'b01, 4'b1110, 16'h0004, 2'b00, 8'h00, 1'b0, 1'b0);
        cycle(2'b01, 4'b1110, 16'h0006, 2'b00, 8'h00, 1'b0, 1'b0);
        cycle(2'b00, 4'b0000, 16'h0000, 2'b11, 8'h64, 1'b0, 1'b0);
        expect_issue("age_0_before_3", 1'b1, 2'd0);
        cycle(2'b00, 4'b0000, 16'h0000, 2'b01, 8'h02, 1'b0, 1'b0);
        expect_issue("age_2_first", 1'b1, 2'd2);
        cycle(2'b00, 4'b0000, 16'h0000, 2'b00, 8'h00, 1'b1, 1'b0);
        expect_issue("age_then_0", 1'b1, 2'd0);
        cycle(2'b00, 4'b0000, 16'h0000, 2'b00, 8'h00, 1'b1, 1'b0);
        cycle(2'b00, 4'b0000, 16'h0000, 2'b01, 8'h09, 1'b1, 1'b0);
        cycle(2'b00, 4'b0000, 16'h0000, 2'b00, 8'h00, 1'b1, 1'b0);
        cycle(2'b00, 4'b0000, 16'h0000, 2'b00, 8'h00, 1'b1, 1'b0);
        expect_state("age_drained", 2'b11, 4'b0100, 3'd0);

        // Single free slot via lane 1, full behaviour, then flush
        cycle(2'b11, 4'b1110, 16'h0009, 2'b00, 8'h00, 1'b0, 1'b0);
        cycle(2'b11, 4'b1010, 16'h0909, 2'b00, 8'h00, 1'b1, 1'b0);
        expect_state("one_free", 2'b01, 4'b0001, 3'd3);
        cycle(2'b10, 4'b1111, 16'h0000, 2'b00, 8'h00, 1'b0, 1'b0);
        expect_state("full", 2'b00, 4'b0000, 3'd4);
        expect_issue("full", 1'b1, 2'd1);
        cycle(2'b00, 4'b0000, 16'h0000, 2'b01, 8'h09, 1'b1, 1'b1);
        expect_state("flush", 2'b11, 4'b0100, 3'd0);
        expect_issue("flush", 1'b0, 2'd0);
        cycle(2'b11, 4'b1111, 16'h0000, 2'b00, 8'h00, 1'b1, 1'b1);
        expect_state("flush_alloc", 2'b11, 4'b0100, 3'd0);
        expect_issue("flush_alloc", 1'b0, 2'd0);

        // Asynchronous reset with three slots busy
        cycle(2'b11, 4'b1010, 16'h0909, 2'b00, 8'h00, 1'b0, 1'b0);
        cycle(2'b01, 4'b1110, 16'h0009, 2'b00, 8'h00, 1'b0, 1'b0);
        expect_state("pre_reset", 2'b01, 4'b0011, 3'd3);
        drive_idle();
        #2;
        rst_n = 1'b0;
        #1;
        expect_state("mid_reset", 2'b11, 4'b0100, 3'd0);
        expect_issue("mid_reset", 1'b0, 2'd0);
        check("mid_reset_issue_index", 32'(bus.issue_index), 32'd0);
        model_reset();
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        expect_state("post_reset", 2'b11, 4'b0100, 3'd0);

        // Random legal traffic
        for (int n = 0; n < 1500; n++) begin
            e = model_out();
            tk = 2'b00;
            if (e.ar == 2'b11) tk = 2'($urandom_range(0, 3));
            else if (e.ar[0]) begin
                pick = int'($urandom_range(0, 2));
                tk = (pick == 0) ? 2'b00 : (pick == 1) ? 2'b01 : 2'b10;
            end
            rd = 4'($urandom);
            for (int k = 0; k < 4; k++) tg[k*4 +: 4] = 4'($urandom_range(0, 7));
            for (int k = 0; k < 2; k++) ct[k*4 +: 4] = 4'($urandom_range(0, 7));
            cycle(tk, rd, tg, 2'($urandom), ct, ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 49) == 0));
        end

        drive_idle();
        @(negedge clk);
        #1;
        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_rs_scheduler.md
Name: alu_rs_scheduler

Overview:
- Slot manager and issue scheduler for the ALU reservation station.
- Supplies the two free-slot ready/index pairs consumed by the dual-issue stage.
- Records per-slot operand-ready state and tags, and wakes operands from CDB broadcasts.
- Each cycle, selects the oldest fully-ready slot for dispatch to the ALU under a valid/ready handshake. Payload storage lives outside; this block owns only busy/ready/tag/age state.

Parameters:
DEPTH, 4, number of RS slots (power of two, >=2)
TAG_W, 4, reorder tag width (rob_index_t width)
CDB_PORTS, 2, number of CDB broadcast ports
IDX_W = $clog2(DEPTH), derived, not overridable

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
flush  in  1  pipeline flush; clears all slots
alloc_ready  out  2  slot free for issue lane 0/1
alloc_index  out  2*IDX_W  slot index per lane
alloc_taken  in  2  lane writes a slot this cycle
alloc_op_ready  in  4  operand-ready bits {lane1.op1,lane1.op0,lane0.op1,lane0.op0}
alloc_op_tag  in  4*TAG_W  operand reorder tags, same ordering
cdb_valid  in  CDB_PORTS  broadcast valid
cdb_tag  in  CDB_PORTS*TAG_W  broadcast reorder tag
issue_valid  out  1  a slot has both operands ready
issue_index  out  IDX_W  oldest ready slot
issue_ready  in  1  ALU accepts issue
occupancy  out  IDX_W+1  busy slot count

Behaviour:
- State per slot: busy, op_ready[1:0], op_tag[1:0]. Age matrix older[i][j] means slot i was allocated before slot j.
- All outputs are combinational from registered state only; no input-to-output paths.
- alloc_index[0]: lowest-numbered free slot. alloc_index[1]: second-lowest free slot.
- alloc_ready[k] = 1 iff that slot exists. A missing slot's index is 0.
- Lane-1 target: alloc_index[1] if alloc_ready[1], else alloc_index[0]. Legal only when alloc_taken[0]=0.
- Driving alloc_taken[k] with no resolved target, or two lanes on one slot, is illegal: assertion fires, state unchanged.
- On allocation at edge t:
  - busy=1; op bits and tags are captured.
  - An operand not ready whose tag matches any valid CDB port in the same cycle is captured ready (same-cycle bypass).
  - The age row is updated: new slot is younger than all busy slots. With dual allocation, lane 0 is older than lane 1.
- Wakeup: every busy slot operand with op_ready=0 and op_tag == a valid cdb_tag sets op_ready=1 at the edge.
- Issue eligibility at cycle t+1 requires both op_ready bits set in registered state. Newly allocated or woken slots are never issued in the same cycle.
- Selection: issue_valid = any eligible slot. issue_index = the eligible slot that is older than every other eligible slot. Ties are impossible by construction.
- Issue handshake: issue_valid & issue_ready at edge frees the slot (busy=0, age row cleared).
- A slot freed at edge t is allocatable from t+1 (its alloc_ready appears only after the edge).
- Slot freed and another allocated in the same cycle: both take effect. Age is relative to the remaining busy set.
- issue_index is stable while issue_valid=1 and issue_ready=0, unless an older slot becomes eligible. Preemption by an older slot is permitted.
- Full: alloc_ready=2'b00, issue continues. Empty: issue_valid=0, occupancy=0.
- occupancy = popcount(busy), registered-state based.
- flush: at the edge all busy, op_ready and age bits clear. Allocation, wakeup and issue in that cycle are discarded.
- Reset (async, any time): same cleared state as flush. Outputs during and after reset: alloc_ready=2'b11, alloc_index={1,0}, issue_valid=0, issue_index=0, occupancy=0.

Test Plan:
- Reset mid-traffic with 3 slots busy -> immediately alloc_ready=11, indices {1,0}, issue_valid=0, occupancy=0.
- Dual alloc into slots 0,1, all ops ready -> next cycle issue_valid=1, issue_index=0. Hold issue_ready=1 -> slot 1 issues the following cycle, then occupancy=0.
- Alloc slot 0 with op0 waiting tag 5 -> issue_valid stays 0. cdb_valid[1]=1, cdb_tag=5 -> issue_valid=1, index=0 the next cycle.
- Same-cycle bypass: alloc with op tag 3 not ready while CDB broadcasts 3 -> slot eligible the cycle after allocation.
- Age order: fill slots 2,0,3 in that order, all waiting. Wake 3 then 0 in the same cycle -> issue_index=0 before 3. With slot 2 woken too -> 2 first.
- Single free slot (slot 1), alloc_taken=2'b10 -> slot 1 busy, alloc_ready=00. Flush simultaneous with alloc -> all slots free, no issue.
